serial_word_loader: RTL and testbench

- Bit-serial deserializer that sits directly upstream of the team's N-bit load/clear register.
- Assembles N serial bits into a word, then drives the register's `in`, `load` and `clear` inputs.
- One-cycle `load` pulse per completed word; one-cycle `clear` pulse on flush.
- Counts completed words for status/debug.

---
 rtl/serial_pkg.sv | 15 +
 rtl/serial_word_loader_bit_counter.sv | 28 ++
 rtl/serial_word_loader.sv | 107 ++++++++++
 tb/tb_serial_word_loader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial word loader.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD,
        CLR
    } ld_state_t;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_word_loader_bit_counter.sv
// Bit position counter: 0..N-1 with sync clear, enable and terminal flag.
module bit_counter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/serial_word_loader.sv
// Deserializes N serial bits into a word and drives a load/clear register.
module serial_word_loader
    import serial_pkg::*;
#(
    parameter int N         = 8,
    parameter int MSB_FIRST = 1,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          sin_valid,
    input  logic          sin_bit,
    output logic          sin_ready,
    input  logic          flush,
    output logic [N-1:0]  word,
    output logic          load,
    output logic          reg_clear,
    output logic          busy,
    output logic [CW-1:0] word_cnt
);

    localparam int CNTW = cnt_width(N);

    ld_state_t       state, state_d;
    logic [N-1:0]    word_d;
    logic [N-1:0]    shifted;
    logic [CW-1:0]   word_cnt_d;
    logic [CNTW-1:0] count;
    logic            tc;
    logic            cnt_clr;
    logic            cnt_en;
    logic            accept;

    assign accept = sin_valid && sin_ready;

    if (MSB_FIRST != 0) begin : g_msb
        assign shifted = {word[N-2:0], sin_bit};
    end else begin : g_lsb
        assign shifted = {sin_bit, word[N-1:1]};
    end

    bit_counter #(
        .N (N),
        .W (CNTW)
    ) u_cnt (
        .clk     (clk),
        .clear_n (clear_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .count   (count),
        .tc      (tc)
    );

    always_comb begin
        state_d    = state;
        word_d     = word;
        word_cnt_d = word_cnt;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        unique case (state)
            IDLE, SHIFT: begin
                // flush beats a simultaneous final bit
                if (flush) begin
                    state_d = CLR;
                    word_d  = '0;
                    cnt_clr = 1'b1;
                end else if (accept) begin
                    word_d  = shifted;
                    cnt_en  = 1'b1;
                    state_d = tc ? LOAD : SHIFT;
                end
            end
            LOAD: begin
                state_d    = IDLE;
                word_cnt_d = word_cnt + CW'(1);
            end
            CLR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SHIFT is held exactly while a partial word is pending
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= IDLE;
            word      <= '0;
            word_cnt  <= '0;
            sin_ready <= 1'b0;
            load      <= 1'b0;
            reg_clear <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            word      <= word_d;
            word_cnt  <= word_cnt_d;
            sin_ready <= (state_d == IDLE) || (state_d == SHIFT);
            load      <= (state_d == LOAD);
            reg_clear <= (state_d == CLR);
            busy      <= (state_d == SHIFT);
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader: MSB/LSB order, gaps, flush, wrap.
module tb_serial_word_loader;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       sin_valid;
    logic       sin_bit;
    logic       flush;

    logic       rdy0, ld0, rc0, bz0;
    logic [7:0] w0, wc0;
    logic       rdy1, ld1, rc1, bz1;
    logic [7:0] w1, wc1;
    logic       rdy2, ld2, rc2, bz2;
    logic [7:0] w2;
    logic [1:0] wc2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_prev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_word_loader #(.N(8), .MSB_FIRST(1), .CW(8)) u0 (
        .clk(clk), .clear_n(clear_n), .sin_valid(sin_valid),
        .sin_bit(sin_bit), .sin_ready(rdy0), .flush(flush),
        .word(w0), .load(ld0), .reg_clear(rc0), .busy(bz0),
        .word_cnt(wc0)
    );

    serial_word_loader #(.N(8), .MSB_FIRST(0), .CW(8)) u1 (
        .clk(clk), .clear_n(clear_n), .sin_valid(sin_valid),
        .sin_bit(sin_bit), .sin_ready(rdy1), .flush(flush),
        .word(w1), .load(ld1), .reg_clear(rc1), .busy(bz1),
        .word_cnt(wc1)
    );

    serial_word_loader #(.N(8), .MSB_FIRST(1), .CW(2)) u2 (
        .clk(clk), .clear_n(clear_n), .sin_valid(sin_valid),
        .sin_bit(sin_bit), .sin_ready(rdy2), .flush(flush),
        .word(w2), .load(ld2), .reg_clear(rc2), .busy(bz2),
        .word_cnt(wc2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // seq[7] is the first bit on the wire
    task automatic send_bits(input logic [7:0] seq, input int n,
                             input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                repeat ($urandom_range(0, 3)) begin
                    sin_valid = 1'b0;
                    @(negedge clk);
                end
            end
            if (i == 7) begin
                chk("no_early_load", {31'b0, ld0}, 32'd0);
                chk("busy_partial", {31'b0, bz0}, 32'd1);
            end
            sin_valid = 1'b1;
            sin_bit   = seq[7-i];
            @(negedge clk);
        end
        sin_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear_n = 1'b0;
        #1;
        chk("rst_word", {24'b0, w0}, 32'd0);
        chk("rst_busy", {31'b0, bz0}, 32'd0);
        chk("rst_cnt", {24'b0, wc0}, 32'd0);
        chk("rst_cnt2", {30'b0, wc2}, 32'd0);
        chk("rst_ready", {31'b0, rdy0}, 32'd0);
        chk("rst_load", {31'b0, ld0}, 32'd0);
        chk("rst_clr", {31'b0, rc0}, 32'd0);
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'b0, rdy0}, 32'd1);
    endtask

    initial begin
        clear_n   = 1'b0;
        sin_valid = 1'b0;
        sin_bit   = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        do_reset();

        // 1,0,1,1,0,0,1,0 back-to-back
        send_bits(8'hB2, 8, 1'b0);
        chk("ld_pulse", {31'b0, ld0}, 32'd1);
        chk("ld_ready", {31'b0, rdy0}, 32'd0);
        chk("msb_word", {24'b0, w0}, 32'hB2);
        chk("lsb_word", {24'b0, w1}, 32'h4D);
        chk("cnt_before", {24'b0, wc0}, 32'd0);
        chk("ld_busy", {31'b0, bz0}, 32'd0);
        @(negedge clk);
        chk("ld_end", {31'b0, ld0}, 32'd0);
        chk("cnt_one", {24'b0, wc0}, 32'd1);
        chk("hold_word", {24'b0, w0}, 32'hB2);
        chk("idle_ready", {31'b0, rdy0}, 32'd1);

        // same stream with random valid gaps
        send_bits(8'hB2, 8, 1'b1);
        chk("gap_ld", {31'b0, ld1}, 32'd1);
        chk("gap_lsb", {24'b0, w1}, 32'h4D);
        chk("gap_msb", {24'b0, w0}, 32'hB2);
        @(negedge clk);
        chk("gap_ld_end", {31'b0, ld1}, 32'd0);
        chk("gap_cnt", {24'b0, wc1}, 32'd2);

        // reset after 3 bits discards the partial word
        send_bits(8'hFF, 3, 1'b0);
        chk("mid_busy", {31'b0, bz0}, 32'd1);
        do_reset();
        send_bits(8'h5C, 8, 1'b0);
        chk("post_rst_ld", {31'b0, ld0}, 32'd1);
        chk("post_rst_word", {24'b0, w0}, 32'h5C);
        @(negedge clk);
        chk("post_rst_cnt", {24'b0, wc0}, 32'd1);

        // flush after 5 bits
        send_bits(8'hB2, 5, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_clr", {31'b0, rc0}, 32'd1);
        chk("fl_load", {31'b0, ld0}, 32'd0);
        chk("fl_word", {24'b0, w0}, 32'd0);
        chk("fl_busy", {31'b0, bz0}, 32'd0);
        chk("fl_ready", {31'b0, rdy0}, 32'd0);
        @(negedge clk);
        chk("fl_clr_end", {31'b0, rc0}, 32'd0);
        chk("fl_cnt", {24'b0, wc0}, 32'd1);
        send_bits(8'hB2, 8, 1'b0);
        chk("fl_next_word", {24'b0, w0}, 32'hB2);
        chk("fl_next_ld", {31'b0, ld0}, 32'd1);
        @(negedge clk);
        chk("fl_next_cnt", {24'b0, wc0}, 32'd2);

        // flush together with the 8th bit
        send_bits(8'hB2, 7, 1'b0);
        sin_valid = 1'b1;
        sin_bit   = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        sin_valid = 1'b0;
        flush     = 1'b0;
        chk("co_clr", {31'b0, rc0}, 32'd1);
        chk("co_load", {31'b0, ld0}, 32'd0);
        chk("co_word", {24'b0, w0}, 32'd0);
        @(negedge clk);
        chk("co_load2", {31'b0, ld0}, 32'd0);
        chk("co_cnt", {24'b0, wc0}, 32'd2);

        // CW=2 wrap, back-to-back words spaced N+1 cycles
        do_reset();
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            send_bits(8'hA5, 8, 1'b0);
            chk("wr_ld", {31'b0, ld2}, 32'd1);
            if (k > 0) chk("wr_space", cyc - t_prev, 32'd9);
            t_prev = cyc;
            @(negedge clk);
            chk("wr_cnt", {30'b0, wc2}, (k + 1) % 4);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
